// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle control path: FSM states,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SUBU = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b1110;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_MOVZ = 4'b1011;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_RS    = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_SIMM = 2'd2;
    localparam logic [1:0] SRC_B_ZIMM = 2'd3;

    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_RS   = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // Instructions whose signed overflow can trap.
    function automatic logic is_ovf_op(input logic [5:0] op, input logic [5:0] funct);
        return ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB))) || (op == OP_ADDI);
    endfunction

    function automatic logic rtype_legal(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_MOVZ,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu_op_dec.sv
// Combinational ALU operation and operand-select decoder, keyed on FSM
// state plus latched opcode/funct; kept standalone for reuse by a pipeline.
module mips_alu_op_dec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b
);

    logic [3:0] r_op;
    logic [3:0] i_op;
    logic       i_zext;

    always_comb begin
        r_op = ALU_ADDU;
        case (funct)
            FN_SLL, FN_SLLV: r_op = ALU_SLL;
            FN_SRL, FN_SRLV: r_op = ALU_SRL;
            FN_SRA, FN_SRAV: r_op = ALU_SRA;
            FN_MOVZ:         r_op = ALU_MOVZ;
            FN_ADD:          r_op = ALU_ADD;
            FN_ADDU:         r_op = ALU_ADDU;
            FN_SUB:          r_op = ALU_SUB;
            FN_SUBU:         r_op = ALU_SUBU;
            FN_AND:          r_op = ALU_AND;
            FN_OR:           r_op = ALU_OR;
            FN_XOR:          r_op = ALU_XOR;
            FN_NOR:          r_op = ALU_NOR;
            default:         r_op = ALU_ADDU;
        endcase
    end

    // Logical immediates and lui take the zero-extended immediate.
    always_comb begin
        i_op   = ALU_ADDU;
        i_zext = 1'b0;
        case (op)
            OP_ADDI:  i_op = ALU_ADD;
            OP_ADDIU: i_op = ALU_ADDU;
            OP_ANDI:  begin i_op = ALU_AND; i_zext = 1'b1; end
            OP_ORI:   begin i_op = ALU_OR;  i_zext = 1'b1; end
            OP_XORI:  begin i_op = ALU_XOR; i_zext = 1'b1; end
            OP_LUI:   begin i_op = ALU_LUI; i_zext = 1'b1; end
            default:  i_op = ALU_ADDU;
        endcase
    end

    always_comb begin
        alu_op    = ALU_ADDU;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        case (state)
            S_FETCH: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_SIMM;
            end
            S_EXEC_R, S_WB_R: begin
                alu_op    = r_op;
                alu_src_b = SRC_B_RT;
                if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA))
                    alu_src_a = SRC_A_SHAMT;
                else
                    alu_src_a = SRC_A_RS;
            end
            S_EXEC_I, S_WB_I: begin
                alu_op    = i_op;
                alu_src_a = SRC_A_RS;
                alu_src_b = i_zext ? SRC_B_ZIMM : SRC_B_SIMM;
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB: begin
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_SIMM;
            end
            S_BRANCH: begin
                alu_op    = ALU_SUBU;
                alu_src_a = SRC_A_RS;
                alu_src_b = SRC_B_RT;
            end
            default: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU op plus datapath strobes from state and the latched opcode/funct.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter bit          OVF_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_disable_reg,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        exc_ovf,
    output logic        exc_illegal,
    output logic [31:0] reset_pc_o
);

    state_t     state, next_state;
    logic [5:0] op_q, funct_q;
    logic       ovf_trap_hit;
    logic       movz_block;
    logic       unused_instr;

    assign reset_pc_o   = RESET_PC;
    assign unused_instr = ^instr[25:6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state <= next_state;
            if ((state == S_FETCH) && mem_ready) begin
                op_q    <= instr[31:26];
                funct_q <= instr[5:0];
            end
        end
    end

    mips_alu_op_dec u_alu_op_dec (
        .state     (state),
        .op        (op_q),
        .funct     (funct_q),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b)
    );

    // The ALU flags are only meaningful in the writeback states.
    assign ovf_trap_hit = OVF_TRAP && is_ovf_op(op_q, funct_q) && alu_overflow;
    assign movz_block   = (op_q == OP_RTYPE) && (funct_q == FN_MOVZ) && alu_disable_reg;

    always_comb begin
        next_state  = state;
        pc_write    = 1'b0;
        pc_source   = PC_SRC_ALU;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = DST_RT;
        mem_to_reg  = M2R_ALU;
        exc_ovf     = 1'b0;
        exc_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_q)
                    OP_RTYPE: begin
                        if (funct_q == FN_JR)
                            next_state = S_JR;
                        else if (rtype_legal(funct_q))
                            next_state = S_EXEC_R;
                        else begin
                            exc_illegal = 1'b1;
                            next_state  = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                        next_state = S_EXEC_I;
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J, OP_JAL:   next_state = S_JUMP;
                    default: begin
                        exc_illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: next_state = S_WB_R;
            S_EXEC_I: next_state = S_WB_I;
            S_WB_R, S_WB_I: begin
                reg_dst    = (state == S_WB_R) ? DST_RD : DST_RT;
                mem_to_reg = M2R_ALU;
                reg_write  = !(movz_block || ovf_trap_hit);
                exc_ovf    = ovf_trap_hit;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = M2R_MDR;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready)
                    next_state = S_FETCH;
            end
            S_BRANCH: begin
                if (((op_q == OP_BEQ) && alu_zero) || ((op_q == OP_BNE) && !alu_zero)) begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_BR;
                end
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC;
                end
                next_state = S_FETCH;
            end
            S_JR: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_RS;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed per-cycle vectors push
// hand-derived expected outputs; a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       exc_ovf;
        logic       exc_illegal;
        logic       check_alu;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready, alu_zero, alu_overflow, alu_disable_reg;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg;
    logic        pc_write, ir_write, mem_req, mem_we, i_or_d, reg_write, exc_ovf, exc_illegal;
    logic [31:0] reset_pc_o;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_disable_reg(alu_disable_reg),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .exc_ovf(exc_ovf),
        .exc_illegal(exc_illegal), .reset_pc_o(reset_pc_o)
    );

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = '0;
        e.alu_src_b = 2'd1; e.mem_req = 1'b1; e.pc_write = rdy; e.ir_write = rdy; e.check_alu = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_decode(input logic ill);
        exp_t e = '0;
        e.alu_src_b = 2'd2; e.exc_illegal = ill; e.check_alu = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
        exp_t e = '0;
        e.alu_op = op; e.alu_src_a = a; e.alu_src_b = b; e.check_alu = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                                  input logic rw, input logic [1:0] dst, input logic ovf);
        exp_t e = e_exec(op, a, b);
        e.reg_write = rw; e.reg_dst = dst; e.exc_ovf = ovf;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic rd, input logic wr, input logic wb);
        exp_t e = '0;
        e.mem_req = rd | wr; e.i_or_d = rd | wr; e.mem_we = wr;
        e.reg_write = wb; e.mem_to_reg = wb ? 2'd1 : 2'd0;
        return e;
    endfunction

    function automatic exp_t e_branch(input logic taken);
        exp_t e = e_exec(4'b1000, 2'd1, 2'd0);
        e.pc_write = taken; e.pc_source = 2'd1;
        return e;
    endfunction

    function automatic exp_t e_jump(input logic [1:0] src, input logic link);
        exp_t e = '0;
        e.pc_write = 1'b1; e.pc_source = src;
        e.reg_write = link; e.reg_dst = link ? 2'd2 : 2'd0; e.mem_to_reg = link ? 2'd2 : 2'd0;
        return e;
    endfunction

    task automatic applyStimulus(input string nm, input logic rst, input logic [31:0] ins,
                                 input logic rdy, input logic z, input logic o, input logic d,
                                 input exp_t e);
        @(posedge clk);
        #1;
        reset = rst; instr = ins; mem_ready = rdy;
        alu_zero = z; alu_overflow = o; alu_disable_reg = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input string nm, input exp_t e);
        exp_t a;
        exp_t x;
        a = '{alu_op, alu_src_a, alu_src_b, pc_write, pc_source, ir_write, mem_req, mem_we,
              i_or_d, reg_write, reg_dst, mem_to_reg, exc_ovf, exc_illegal, e.check_alu};
        x = e;
        if (!e.check_alu) begin
            a.alu_op = 4'd0; a.alu_src_a = 2'd0; a.alu_src_b = 2'd0;
            x.alu_op = 4'd0; x.alu_src_a = 2'd0; x.alu_src_b = 2'd0;
        end
        if (!e.pc_write) begin
            a.pc_source = 2'd0;
            x.pc_source = 2'd0;
        end
        checks++;
        if (a !== x) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h (op/srcA/srcB/pcw/pcs/irw/mreq/mwe/iord/rw/dst/m2r/ovf/ill)",
                     nm, a, x);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checkOutput(nm, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_ADD   = 32'h0022_1820;
    localparam logic [31:0] I_ADDI  = 32'h2022_0005;
    localparam logic [31:0] I_MOVZ  = 32'h0022_180A;
    localparam logic [31:0] I_SLL   = 32'h0002_1900;
    localparam logic [31:0] I_ORI   = 32'h3422_00FF;
    localparam logic [31:0] I_LW    = 32'h8C22_0004;
    localparam logic [31:0] I_SW    = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_BNE   = 32'h1422_0003;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_JAL   = 32'h0C00_0010;
    localparam logic [31:0] I_JR    = 32'h03E0_0008;
    localparam logic [31:0] I_BAD   = 32'hFC00_0000;

    // Runs an R-type from fetch through writeback with the given flags in WB.
    task automatic runR(input string nm, input logic [31:0] ins, input logic [3:0] op,
                        input logic [1:0] a, input logic o, input logic d,
                        input logic rw, input logic ovf);
        applyStimulus({nm, "_fetch"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus({nm, "_decode"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus({nm, "_exec"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(op, a, 2'd0));
        applyStimulus({nm, "_wb"}, 1'b0, ins, 1'b1, 1'b0, o, d, e_wb(op, a, 2'd0, rw, 2'd1, ovf));
    endtask

    initial begin : stimulus
        reset = 1'b1; instr = 32'd0; mem_ready = 1'b1;
        alu_zero = 1'b0; alu_overflow = 1'b0; alu_disable_reg = 1'b0;
        repeat (2) @(posedge clk);

        applyStimulus("reset_fetch", 1'b1, I_ADDU, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        runR("addu", I_ADDU, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus("lw_fetch_w1", 1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        applyStimulus("lw_fetch_w2", 1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        applyStimulus("lw_fetch", 1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("lw_decode", 1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("lw_addr", 1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(4'b0000, 2'd1, 2'd2));
        applyStimulus("lw_rd_w1", 1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
        applyStimulus("lw_rd_w2", 1'b0, I_LW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
        applyStimulus("lw_rd", 1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
        applyStimulus("lw_wb", 1'b0, I_LW, 1'b1, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0, 1'b1));

        applyStimulus("beq_t_fetch", 1'b0, I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("beq_t_decode", 1'b0, I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("beq_taken", 1'b0, I_BEQ, 1'b1, 1'b1, 1'b0, 1'b0, e_branch(1'b1));
        applyStimulus("beq_n_fetch", 1'b0, I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("beq_n_decode", 1'b0, I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("beq_not_taken", 1'b0, I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_branch(1'b0));
        applyStimulus("bne_fetch", 1'b0, I_BNE, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("bne_decode", 1'b0, I_BNE, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("bne_taken", 1'b0, I_BNE, 1'b1, 1'b0, 1'b0, 1'b0, e_branch(1'b1));

        runR("add_ovf", I_ADD, 4'b1001, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        runR("addu_ovf", I_ADDU, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        runR("movz_block", I_MOVZ, 4'b1011, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        runR("movz_write", I_MOVZ, 4'b1011, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        runR("sll", I_SLL, 4'b1010, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);

        applyStimulus("addi_fetch", 1'b0, I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("addi_decode", 1'b0, I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("addi_exec", 1'b0, I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(4'b1001, 2'd1, 2'd2));
        applyStimulus("addi_wb_ovf", 1'b0, I_ADDI, 1'b1, 1'b0, 1'b1, 1'b0,
                      e_wb(4'b1001, 2'd1, 2'd2, 1'b0, 2'd0, 1'b1));
        applyStimulus("ori_fetch", 1'b0, I_ORI, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("ori_decode", 1'b0, I_ORI, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("ori_exec", 1'b0, I_ORI, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(4'b0101, 2'd1, 2'd3));
        applyStimulus("ori_wb", 1'b0, I_ORI, 1'b1, 1'b0, 1'b0, 1'b0,
                      e_wb(4'b0101, 2'd1, 2'd3, 1'b1, 2'd0, 1'b0));

        applyStimulus("j_fetch", 1'b0, I_J, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("j_decode", 1'b0, I_J, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("j_jump", 1'b0, I_J, 1'b1, 1'b0, 1'b0, 1'b0, e_jump(2'd2, 1'b0));
        applyStimulus("jal_fetch", 1'b0, I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("jal_decode", 1'b0, I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("jal_jump", 1'b0, I_JAL, 1'b1, 1'b0, 1'b0, 1'b0, e_jump(2'd2, 1'b1));
        applyStimulus("jr_fetch", 1'b0, I_JR, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("jr_decode", 1'b0, I_JR, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("jr_jump", 1'b0, I_JR, 1'b1, 1'b0, 1'b0, 1'b0, e_jump(2'd3, 1'b0));

        applyStimulus("bad_fetch", 1'b0, I_BAD, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("bad_decode", 1'b0, I_BAD, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b1));
        applyStimulus("bad_refetch", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));

        applyStimulus("sw_decode", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("sw_addr", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(4'b0000, 2'd1, 2'd2));
        applyStimulus("sw_wr_w1", 1'b0, I_SW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1, 1'b0));
        applyStimulus("sw_wr_rst", 1'b1, I_SW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1, 1'b0));
        applyStimulus("sw_rst_fetch", 1'b0, I_SW, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
        applyStimulus("sw_fetch", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
        applyStimulus("sw_decode2", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
        applyStimulus("sw_addr2", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_exec(4'b0000, 2'd1, 2'd2));
        applyStimulus("sw_wr", 1'b0, I_SW, 1'b1, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1, 1'b0));
        applyStimulus("sw_done_fetch", 1'b0, I_ADDU, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        checks++;
        if (reset_pc_o !== 32'h0000_3000) begin
            failures++;
            $display("[TB] FAIL reset_pc: actual=%h required=%h", reset_pc_o, 32'h0000_3000);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
